imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time writer for the core's byte-addressed instruction memory, which the core otherwise only reads. It takes a framed byte stream on a valid/ready interface, packs the bytes into little-endian 32-bit words and issues one-cycle writes to the instruction memory write port. It holds the core in reset until a frame is loaded and its checksum verifies, then releases the core so it fetches from BASE_ADDR.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
MAX_WORDS, 256, largest accepted word count (instruction memory of 1024 bytes / 4).
SYNC_BYTE, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 1000, maximum idle cycles between bytes inside a frame.

Ports:
clk  input  1  clock, all logic on the rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  in_data holds a byte.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
wr_en  output  1  instruction memory write strobe, one cycle per word.
wr_addr  output  32  byte address of the word, always word-aligned.
wr_data  output  32  word to write; byte 0 of the word sits at wr_data[7:0].
cpu_rst  output  1  active-high reset to the core.
done  output  1  last frame loaded with a good checksum.
err  output  1  last frame failed on length, checksum or timeout.

Behaviour:
- Reset values (all outputs registered), from rst_n low:
  - in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0.
  - cpu_rst=1, done=0, err=0.
  - state=IDLE, all counters 0.
  - in_ready rises on the first cycle after rst_n goes high.
- Reset mid-operation: the above applies on the next edge. A partly assembled word is discarded and never written.
- Frame format, in order:
  - SYNC_BYTE.
  - N[7:0], then N[15:8].
  - 4*N payload bytes; each word is sent LSB first.
  - CHK: XOR of all payload bytes only, so CHK=8'h00 when N=0.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
- IDLE / DONE / ERR:
  - An accepted byte equal to SYNC_BYTE moves to LEN0 and sets cpu_rst=1, done=0, err=0 on the same edge.
  - Any other byte is consumed and dropped.
  - in_ready=1 in these states.
- LEN0: the accepted byte loads N[7:0]; go to LEN1.
- LEN1: the accepted byte loads N[15:8]. Then:
  - N > MAX_WORDS: go to ERR, nothing written.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA with word index 0, byte index 0, checksum 0.
- DATA: each accepted byte lands in lane (byte index × 8) of the shift buffer and is XORed into the running checksum. Byte indices 0..2 just increment; byte index 3 goes to WRITE.
- WRITE: lasts exactly one cycle.
  - wr_en=1, wr_addr=BASE_ADDR + 4*word_index (32-bit modulo), wr_data=assembled word.
  - in_ready=0. Any held byte stays pending and is not lost.
  - Next state: DATA with word_index+1 if more words remain, otherwise CSUM.
  - Latency: last byte of a word accepted at edge k → wr_en high during cycle k+1.
- CSUM: the accepted byte is compared with the running checksum.
  - Match: go to DONE; done=1 and cpu_rst=0 from the next cycle on.
  - Mismatch: go to ERR; err=1, cpu_rst stays 1.
  - Words already written are not rolled back.
- Timeout (LEN0, LEN1, DATA, CSUM):
  - An idle counter clears on every accepted byte and on state entry, and increments otherwise.
  - Reaching TIMEOUT_CYCLES goes to ERR.
  - WRITE does not count as idle.
- wr_en is 0 in every state except WRITE. wr_addr and wr_data hold their last values.
- done and err are never both 1. Both are levels held until the next sync byte or reset.

Test Plan:
- Reset, then send A5 02 00 33 01 11 00 13 82 40 83 71. Expect:
  - wr_en @0 with 32'h00110133.
  - wr_en @4 with 32'h83408213.
  - done=1 and cpu_rst=0 on the cycle after 71 is accepted; err=0.
- Same frame with CHK=70. Expect both writes to still occur, then err=1, done=0, cpu_rst=1.
- Send A5 01 01 (N=257). Expect ERR after LEN1, no wr_en, err=1.
- Send 00 FF A5 00 00 00. Expect the leading bytes dropped, no writes, done=1.
- Send A5 then hold in_valid=0. Expect err=1 exactly TIMEOUT_CYCLES=1000 cycles later. A following good frame ends in done=1, err=0.
- Backpressure and mid-load reset:
  - With in_valid held high continuously, check in_ready=0 in every WRITE cycle and that no byte is dropped or duplicated (compare against the written words).
  - Pulse rst_n low during the third byte of word 1. Expect all outputs at their reset values, no write for word 1, and a clean restart.

Source files
------------

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Bundles the signals between the boot loader, its byte-stream source and
//   the instruction memory write port / core control.
//
//   Stream   : in_valid, in_data[7:0]  (source -> loader)
//              in_ready                (loader -> source)
//   Memory   : wr_en, wr_addr[31:0], wr_data[31:0]  (loader -> memory)
//   Status   : cpu_rst (active-high core reset), done, err  (loader -> system)
//
//   slave  : the loader side.
//   master : the stream source / observer side.
// ---------------------------------------------------------------------------
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
    );
endinterface : imem_loader_if

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time loader for the instruction memory. Receives a framed byte
//   stream (SYNC, N lo, N hi, 4*N payload bytes LSB-first per word, XOR
//   checksum), packs little-endian 32-bit words and writes them one per
//   cycle starting at BASE_ADDR. The core is held in reset until a frame
//   with a good checksum has been loaded.
//
//   Ports:
//     clk   : clock, rising edge.
//     rst_n : synchronous active-low reset.
//     bus   : imem_loader_if.slave -- byte stream in, memory write port out,
//             cpu_rst / done / err status out. All outputs are registered.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 256,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Registered state
    state_t              r_state;
    logic [15:0]         r_len;
    logic [15:0]         r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_csum;
    logic [31:0]         r_buf;
    logic [IDLE_W-1:0]   r_idle;
    logic                r_in_ready;
    logic                r_wr_en;
    logic [31:0]         r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_err;

    // Next-state values
    state_t              w_state_next;
    logic [15:0]         w_len_next;
    logic [15:0]         w_word_idx_next;
    logic [1:0]          w_byte_idx_next;
    logic [7:0]          w_csum_next;
    logic [31:0]         w_buf_next;
    logic [IDLE_W-1:0]   w_idle_next;
    logic [31:0]         w_wr_addr_next;
    logic [31:0]         w_wr_data_next;
    logic                w_cpu_rst_next;
    logic                w_done_next;
    logic                w_err_next;
    logic [15:0]         w_n;
    logic                w_fire;
    logic                w_counting;

    assign w_fire = bus.in_valid && r_in_ready;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned; a missing default would infer a latch.
        w_state_next    = r_state;
        w_len_next      = r_len;
        w_word_idx_next = r_word_idx;
        w_byte_idx_next = r_byte_idx;
        w_csum_next     = r_csum;
        w_buf_next      = r_buf;
        w_idle_next     = '0;
        w_wr_addr_next  = r_wr_addr;
        w_wr_data_next  = r_wr_data;
        w_cpu_rst_next  = r_cpu_rst;
        w_done_next     = r_done;
        w_err_next      = r_err;
        w_n             = {bus.in_data, r_len[7:0]};
        w_counting      = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_fire && bus.in_data == SYNC_BYTE) begin
                    w_state_next   = S_LEN0;
                    w_cpu_rst_next = 1'b1;
                    w_done_next    = 1'b0;
                    w_err_next     = 1'b0;
                end
            end

            S_LEN0: begin
                w_counting = 1'b1;
                if (w_fire) begin
                    w_len_next[7:0] = bus.in_data;
                    w_state_next    = S_LEN1;
                end
            end

            S_LEN1: begin
                w_counting = 1'b1;
                if (w_fire) begin
                    w_len_next      = w_n;
                    w_word_idx_next = '0;
                    w_byte_idx_next = '0;
                    w_csum_next     = '0;
                    if (32'(w_n) > MAX_WORDS) begin
                        w_state_next = S_ERR;
                        w_err_next   = 1'b1;
                    end else if (w_n == 16'd0) begin
                        w_state_next = S_CSUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end

            S_DATA: begin
                w_counting = 1'b1;
                if (w_fire) begin
                    w_buf_next[{r_byte_idx, 3'b000} +: 8] = bus.in_data;
                    w_csum_next     = r_csum ^ bus.in_data;
                    w_byte_idx_next = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        // Present the completed word on the write port during
                        // the single WRITE cycle that follows.
                        w_state_next   = S_WRITE;
                        w_wr_addr_next = BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                        w_wr_data_next = w_buf_next;
                    end
                end
            end

            S_WRITE: begin
                w_word_idx_next = r_word_idx + 16'd1;
                if (r_word_idx + 16'd1 == r_len) begin
                    w_state_next = S_CSUM;
                end else begin
                    w_state_next = S_DATA;
                end
            end

            S_CSUM: begin
                w_counting = 1'b1;
                if (w_fire) begin
                    if (bus.in_data == r_csum) begin
                        w_state_next   = S_DONE;
                        w_done_next    = 1'b1;
                        w_cpu_rst_next = 1'b0;
                    end else begin
                        w_state_next = S_ERR;
                        w_err_next   = 1'b1;
                    end
                end
            end

            default: w_state_next = S_IDLE;
        endcase

        // Idle timeout inside a frame. An accepted byte or any state entry
        // leaves the counter at zero; every entry into a counting state
        // happens either on an accepted byte or from WRITE, which does not
        // count, so the default of zero covers both.
        if (w_counting && !w_fire) begin
            if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                w_state_next = S_ERR;
                w_err_next   = 1'b1;
            end else begin
                w_idle_next = r_idle + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_buf      <= '0;
            r_idle     <= '0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= '0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_len      <= w_len_next;
            r_word_idx <= w_word_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_csum     <= w_csum_next;
            r_buf      <= w_buf_next;
            r_idle     <= w_idle_next;
            // Registered handshake: ready is withheld exactly in WRITE, so a
            // held byte simply waits one cycle.
            r_in_ready <= (w_state_next != S_WRITE);
            r_wr_en    <= (w_state_next == S_WRITE);
            r_wr_addr  <= w_wr_addr_next;
            r_wr_data  <= w_wr_data_next;
            r_cpu_rst  <= w_cpu_rst_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.cpu_rst  = r_cpu_rst;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Frames are built from lists of
//   words; each word's expected memory write is queued when the frame is
//   issued, and a monitor on the falling edge pops and compares whenever
//   wr_en is seen. Frame status (done/err/cpu_rst) is checked after the last
//   byte of each frame is accepted.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam logic [31:0] BASE_ADDR      = 32'h0000_0000;
    localparam int unsigned MAX_WORDS      = 256;
    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
    localparam int unsigned TIMEOUT_CYCLES = 1000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    wr_t  exp_q[$];

    imem_loader_if bus ();

    imem_loader #(
        .BASE_ADDR     (BASE_ADDR),
        .MAX_WORDS     (MAX_WORDS),
        .SYNC_BYTE     (SYNC_BYTE),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected
    // write, and the loader must be refusing bytes while it writes.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.wr_en === 1'b1) begin
            check("ready_low_in_write", 32'(bus.in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e.addr);
                check("wr_data", bus.wr_data, e.data);
            end
        end
    end

    // Offer one byte and wait (bounded) for it to be taken. Returns #1 after
    // the accepting edge, so registered outputs already reflect that byte.
    task automatic send_byte(input logic [7:0] b, input bit hold_valid);
        bit ok;
        int waited;
        ok     = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = (bus.in_ready === 1'b1);
            @(posedge clk);
            waited++;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: byte %h not accepted in %0d cycles, required acceptance", b, waited);
        end
        #1;
        if (!hold_valid) bus.in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a frame is its word list; the bytes on the wire and
    // the checksum follow from the frame format, and every word is expected
    // at BASE_ADDR + 4*index.
    task automatic send_frame(input logic [31:0] words[$], input logic [7:0] chk_flip,
                              input int gap_max, input bit back_to_back);
        logic [7:0]  bytes[$];
        logic [7:0]  chk;
        logic [15:0] n;
        logic [7:0]  b;
        wr_t         e;
        n   = 16'(words.size());
        chk = 8'h00;
        bytes.push_back(SYNC_BYTE);
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        foreach (words[i]) begin
            e.addr = BASE_ADDR + 32'(i) * 32'd4;
            e.data = words[i];
            exp_q.push_back(e);
            for (int j = 0; j < 4; j++) begin
                b   = words[i][8*j +: 8];
                chk = chk ^ b;
                bytes.push_back(b);
            end
        end
        bytes.push_back(chk ^ chk_flip);
        foreach (bytes[k]) begin
            send_byte(bytes[k], back_to_back && (k != bytes.size() - 1));
            if (!back_to_back && gap_max > 0) idle_gap(int'($urandom_range(gap_max, 0)));
        end
    endtask

    task automatic check_status(input string name, input bit exp_done, input bit exp_err);
        check({name, "_done"},    32'(bus.done),    32'(exp_done));
        check({name, "_err"},     32'(bus.err),     32'(exp_err));
        check({name, "_cpu_rst"}, 32'(bus.cpu_rst), 32'(!exp_done));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({name, "_wr_en"},    32'(bus.wr_en),    32'd0);
        check({name, "_wr_addr"},  bus.wr_addr,       BASE_ADDR);
        check({name, "_wr_data"},  bus.wr_data,       32'd0);
        check({name, "_cpu_rst"},  32'(bus.cpu_rst),  32'd1);
        check({name, "_done"},     32'(bus.done),     32'd0);
        check({name, "_err"},      32'(bus.err),      32'd0);
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] words[$];
        int          rise;
        int          n;
        bit          bad;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state and ready rising one cycle after release.
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);

        // Known-good two-word frame: A5 02 00 33 01 11 00 13 82 40 83 71.
        words = '{32'h0011_0133, 32'h8340_8213};
        send_frame(words, 8'h00, 0, 1'b0);
        check_status("good_frame", 1'b1, 1'b0);

        // Same frame with CHK=70: writes still happen, then error.
        words = '{32'h0011_0133, 32'h8340_8213};
        send_frame(words, 8'h01, 0, 1'b0);
        check_status("bad_chk", 1'b0, 1'b1);

        // N = 257 exceeds MAX_WORDS: error right after the length, no writes.
        send_byte(SYNC_BYTE, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check_status("len_257", 1'b0, 1'b1);

        // Leading junk is dropped; an empty frame with CHK=00 is good.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        words.delete();
        send_frame(words, 8'h00, 0, 1'b0);
        check_status("empty_frame", 1'b1, 1'b0);

        // Timeout: err must rise exactly TIMEOUT_CYCLES edges after the sync.
        send_byte(SYNC_BYTE, 1'b0);
        rise = 0;
        for (int i = 1; i <= int'(TIMEOUT_CYCLES) + 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.err === 1'b1) begin
                rise = i;
                break;
            end
        end
        check("timeout_cycles", 32'(rise), 32'(TIMEOUT_CYCLES));
        check_status("timeout", 1'b0, 1'b1);
        words = '{32'hDEAD_BEEF};
        send_frame(words, 8'h00, 0, 1'b0);
        check_status("after_timeout", 1'b1, 1'b0);

        // Randomized frames, alternating continuous valid and random gaps.
        for (int f = 0; f < 12; f++) begin
            words.delete();
            n = int'($urandom_range(6, 0));
            for (int i = 0; i < n; i++) words.push_back($urandom);
            bad = ($urandom_range(3, 0) == 0);
            send_frame(words, bad ? 8'($urandom_range(255, 1)) : 8'h00, 3, f[0]);
            check_status($sformatf("rand_frame%0d", f), !bad, bad);
        end

        // Largest accepted frame, sent back to back.
        words.delete();
        for (int i = 0; i < int'(MAX_WORDS); i++) words.push_back($urandom);
        send_frame(words, 8'h00, 0, 1'b1);
        check_status("max_words", 1'b1, 1'b0);

        // Reset while the third byte of word 1 is on the bus: word 0 is
        // written, word 1 never is.
        begin
            wr_t e;
            send_byte(SYNC_BYTE, 1'b1);
            send_byte(8'h03, 1'b1);
            send_byte(8'h00, 1'b1);
            e.addr = BASE_ADDR;
            e.data = 32'h4433_2211;
            exp_q.push_back(e);
            send_byte(8'h11, 1'b1);
            send_byte(8'h22, 1'b1);
            send_byte(8'h33, 1'b1);
            send_byte(8'h44, 1'b1);
            send_byte(8'h55, 1'b1);
            send_byte(8'h66, 1'b1);
            bus.in_data = 8'h77;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            check_reset_values("mid_reset");
            check("mid_reset_pending", 32'(exp_q.size()), 32'd0);
            bus.in_valid = 1'b0;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("ready_after_mid_reset", 32'(bus.in_ready), 32'd1);
        end

        words = '{32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C};
        send_frame(words, 8'h00, 0, 1'b1);
        check_status("restart", 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_imem_loader
